// File: rtl/preload_loader.sv
// Fills a DEPTH-entry holding buffer from a valid/ready stream, then preloads it downstream with one out_wr strobe and drains it with DEPTH out_en shifts.
// Load happens the cycle after the buffer fills and the previous drain is done. A full buffer blocks in_ready until then.
module preload_loader #(
  parameter int DEPTH = 8,
  parameter int BITS  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BITS-1:0]             in_data,
  input  logic                        advance,
  input  logic                        flush,
  output logic [DEPTH-1:0][BITS-1:0]  out_d,
  output logic                        out_wr,
  output logic                        out_en,
  output logic                        busy,
  output logic                        done
);

  localparam int              CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);
  localparam logic [CW-1:0]   ONE  = CW'(1);

  logic [CW-1:0]              r_fill_cnt;
  logic [CW-1:0]              r_drain_cnt;
  logic [DEPTH-1:0][BITS-1:0] r_hold;
  logic                       r_done;

  logic w_accept;
  logic w_load;
  logic w_shift;
  logic w_last;

  assign in_ready = (r_fill_cnt < FULL) && !flush;
  assign w_accept = in_valid && in_ready;
  // Load only once the previous drain has fully finished, which gives the bubble on a coincident last shift.
  assign w_load   = (r_fill_cnt == FULL) && (r_drain_cnt == '0) && !flush;
  assign busy     = (r_drain_cnt != '0);
  assign w_shift  = busy && advance && !w_load && !flush;
  assign w_last   = w_shift && (r_drain_cnt == ONE);

  assign out_wr = w_load;
  assign out_en = w_shift;
  assign out_d  = r_hold;
  assign done   = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill_cnt <= '0;
    end else if (flush || w_load) begin
      r_fill_cnt <= '0;
    end else if (w_accept) begin
      r_fill_cnt <= r_fill_cnt + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drain_cnt <= '0;
    end else if (flush) begin
      r_drain_cnt <= '0;
    end else if (w_load) begin
      r_drain_cnt <= FULL;
    end else if (w_shift) begin
      r_drain_cnt <= r_drain_cnt - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (r_fill_cnt == CW'(k)) begin
          r_hold[k] <= in_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
    end
  end

endmodule

// File: doc/preload_loader.md
PRELOAD_LOADER -- requirements
Module: preload_loader

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the number of entries per frame (>=2).
REQ-002 Parameter BITS, default 8, SHALL set the entry width.
REQ-003 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL indicate that in_data holds a word.
REQ-006 in_ready  output  1  SHALL indicate the holding buffer accepts a word this cycle.
REQ-007 in_data  input  BITS  SHALL be the incoming word; a beat is accepted when in_valid && in_ready.
REQ-008 advance  input  1  SHALL be the downstream request to shift one entry out.
REQ-009 flush  input  1  SHALL synchronously discard the partial frame and abort any drain.
REQ-010 out_d  output  DEPTH x BITS  SHALL be the preload vector fed to the downstream preload FIFO d port.
REQ-011 out_wr  output  1  SHALL be the one-cycle preload strobe to the downstream FIFO.
REQ-012 out_en  output  1  SHALL be the downstream FIFO shift enable.
REQ-013 busy  output  1  SHALL be high while a drain is in progress.
REQ-014 done  output  1  SHALL pulse for one cycle after the final shift of a frame.

Function
REQ-015 Holding buffer: DEPTH registers plus fill_cnt (0..DEPTH); the k-th accepted beat of a frame SHALL be stored in out_d[k], with k = 0 first.
REQ-016 in_ready SHALL equal (fill_cnt < DEPTH) && !flush, as a function of registered state only.
REQ-017 Each accepted beat SHALL increment fill_cnt by 1; fill_cnt SHALL saturate at DEPTH with no wrap.
REQ-018 out_d SHALL be driven directly from the holding registers, stable while fill_cnt == DEPTH.
REQ-019 Drain counter drain_cnt (0..DEPTH); busy SHALL equal (drain_cnt != 0).
REQ-020 Load event: when fill_cnt == DEPTH && drain_cnt == 0 && !flush, out_wr SHALL be 1 for that cycle.
REQ-021 On a load event, the next state SHALL have fill_cnt = 0 and drain_cnt = DEPTH.
REQ-022 out_en SHALL equal busy && advance && !out_wr.
REQ-023 Each cycle with out_en = 1 SHALL decrement drain_cnt by 1.
REQ-024 done SHALL be registered, high exactly the cycle after drain_cnt goes 1 -> 0.
REQ-025 Overlap: beats SHALL be accepted during a drain; the next frame fills while the current one drains.
REQ-026 A full buffer SHALL wait, with in_ready = 0, until drain_cnt == 0; it SHALL never overwrite out_d while waiting.
REQ-027 If the final shift and a full buffer coincide, the load SHALL occur the following cycle (one bubble cycle, no same-cycle load).
REQ-028 advance while busy = 0 SHALL be ignored: no out_en and no state change.
REQ-029 flush SHALL set fill_cnt = 0 and drain_cnt = 0 next cycle.
REQ-030 flush SHALL force out_wr = 0 and out_en = 0 in the flush cycle, and a beat offered that cycle SHALL be dropped.
REQ-031 flush SHALL NOT assert done.
REQ-032 The block SHALL emit exactly DEPTH out_en pulses between consecutive out_wr pulses, absent flush.

Reset
REQ-033 rst_n low SHALL immediately clear fill_cnt, drain_cnt, done and all holding registers to 0.
REQ-034 During reset, outputs SHALL be: in_ready = 1, out_wr = 0, out_en = 0, busy = 0, done = 0, out_d all 0.
REQ-035 Reset asserted mid-fill or mid-drain SHALL discard all data; no out_wr or out_en SHALL follow the release.
REQ-036 After reset release, the first accepted beat SHALL land in out_d[0].

Verification (DEPTH=4, BITS=8)
REQ-037 Basic: beats 0x11, 0x22, 0x33, 0x44 with advance = 1 -> out_wr one cycle later with out_d = {0x11, 0x22, 0x33, 0x44}, then out_en for 4 consecutive cycles, then done one cycle later.
REQ-038 Overlap: stream 8 beats 0x01..0x08 with advance = 1 -> second out_wr carries {0x05..0x08}, exactly 4 out_en pulses between loads, and one bubble cycle when the second fill completes on the last shift.
REQ-039 Backpressure: advance held 0 after the first load while 4 more beats arrive -> in_ready = 0 after the 4th beat, out_d unchanged, no second out_wr until 4 advances complete.
REQ-040 Gaps: advance toggles 1, 0, 1, 0 -> out_en only on advance-high cycles, busy stays 1 until the 4th out_en, done afterwards.
REQ-041 Flush: flush after 2 beats -> fill_cnt = 0, the next 4 beats 0xA0..0xA3 load as {0xA0..0xA3}; flush mid-drain -> busy = 0 next cycle and no done.
REQ-042 Reset: rst_n pulsed low mid-drain -> all outputs at reset values immediately, no out_en after release, and the next frame loads normally.
